mandelbrot_iter_stream: RTL and testbench

Parametrised multi-cycle Mandelbrot pixel generator producing one AXI4-Stream video word per pixel for the VDMA/video path. It replaces the one-pixel-per-cycle behavioural generator with a synthesisable signed fixed-point iterator that performs one z-iteration per clock. Frame size, fixed-point format and iteration width are set by parameters. The viewport and iteration limit are runtime inputs, latched at each frame start, and are normally driven from the AXI-Lite register file.

---
 rtl/mandelbrot_iter_stream.sv | 218 +++++++++++++++++++++
 tb/tb_mandelbrot_iter_stream.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_iter_stream.sv
// Multi-cycle Mandelbrot pixel generator. It emits one AXI4-Stream video word
// per pixel and performs one signed fixed-point z-iteration per clock.
// The viewport (re0, im0, step) and the iteration limit are copied into shadow
// registers when pixel (0,0) is loaded, so a frame always uses one consistent
// configuration.
// Optional build macro: MANDEL_PALETTE_EN selects the polynomial colour palette.
// When it is undefined, the output is greyscale.
module mandelbrot_iter_stream #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480,
  parameter int WIDTH  = 32,
  parameter int FRAC   = 28,
  parameter int ITER_W = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     enable,
  input  logic signed [WIDTH-1:0]  cfg_re0,
  input  logic signed [WIDTH-1:0]  cfg_im0,
  input  logic signed [WIDTH-1:0]  cfg_step,
  input  logic [ITER_W-1:0]        cfg_max_iter,
  output logic [31:0]              out_stream_tdata,
  output logic [3:0]               out_stream_tkeep,
  output logic                     out_stream_tlast,
  output logic                     out_stream_tuser,
  output logic                     out_stream_tvalid,
  input  logic                     out_stream_tready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int XW   = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW   = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam int P_W  = 2 * WIDTH;
  localparam int SQ_W = 2 * WIDTH - FRAC;

  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  // Escape threshold |z|^2 > 4.0. It is held at the full squared width, one bit
  // wider so that the sum of two squares cannot overflow.
  localparam logic signed [SQ_W:0] ESC_LIM = (SQ_W + 1)'(4) << FRAC;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  // Full-precision signed product of two fixed-point values.
  function automatic logic signed [P_W-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b);
    return P_W'(a) * P_W'(b);
  endfunction

  // Computes a*a >>> FRAC and keeps the result at 2*WIDTH-FRAC bits. No
  // truncation is applied, so the escape compare sees the exact magnitude.
  function automatic logic signed [SQ_W-1:0] fx_sq(input logic signed [WIDTH-1:0] a);
    logic signed [P_W-1:0] p;
    p = fx_mul(a, a);
    return p[P_W-1:FRAC];
  endfunction

  // Computes (2*a*b) >>> FRAC and wraps the result to WIDTH bits. Multiplying
  // by 2 is the same as shifting right by one bit less.
  function automatic logic signed [WIDTH-1:0] fx_cross2(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
    logic signed [P_W-1:0] p;
    p = fx_mul(a, b);
    return p[FRAC-1 +: WIDTH];
  endfunction

  // Maps an iteration count to a {R,G,B,8'h00} word. Every product is
  // taken mod 256.
  function automatic logic [31:0] colour(input logic [ITER_W-1:0] d);
    logic [7:0] d8;
`ifdef MANDEL_PALETTE_EN
    logic [7:0] sq;
    logic [7:0] cu;
    d8 = 8'(d);
    sq = d8 * d8;
    cu = sq * d8;
    return {sq, cu, d8, 8'h00};
`else
    d8 = 8'(d);
    return {d8, d8, d8, 8'h00};
`endif
  endfunction

  logic [1:0]               state;
  logic [XW-1:0]            x;
  logic [YW-1:0]            y;
  logic [ITER_W-1:0]        iter;

  logic signed [WIDTH-1:0]  re0_s;
  logic signed [WIDTH-1:0]  im0_s;
  logic signed [WIDTH-1:0]  step_s;
  logic [ITER_W-1:0]        max_iter_s;
  logic signed [WIDTH-1:0]  cr;
  logic signed [WIDTH-1:0]  ci;
  logic signed [WIDTH-1:0]  zr;
  logic signed [WIDTH-1:0]  zi;

  logic signed [SQ_W-1:0]   zr2;
  logic signed [SQ_W-1:0]   zi2;
  logic signed [SQ_W:0]     mag;
  logic signed [WIDTH-1:0]  zr_nxt;
  logic signed [WIDTH-1:0]  zi_nxt;
  logic                     escape;
  logic                     iter_done;
  logic                     first_px;
  logic                     x_wrap;
  logic                     y_wrap;
  logic                     hs;

  // Iteration datapath: squares, escape test and the next z value.
  always_comb begin
    zr2       = fx_sq(zr);
    zi2       = fx_sq(zi);
    mag       = (SQ_W + 1)'(zr2) + (SQ_W + 1)'(zi2);
    escape    = (mag > ESC_LIM);
    zr_nxt    = zr2[WIDTH-1:0] - zi2[WIDTH-1:0] + cr;
    zi_nxt    = fx_cross2(zr, zi) + ci;
    iter_done = escape || (iter == max_iter_s);
    first_px  = (x == '0) && (y == '0);
    x_wrap    = (x == X_LAST);
    y_wrap    = (y == Y_LAST);
    hs        = out_stream_tvalid && out_stream_tready;
  end

  // Control: pixel FSM, raster position, iteration count and output word.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state             <= S_IDLE;
      x                 <= '0;
      y                 <= '0;
      iter              <= '0;
      out_stream_tvalid <= 1'b0;
      out_stream_tdata  <= '0;
      out_stream_tlast  <= 1'b0;
      out_stream_tuser  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) state <= S_LOAD;
        end
        S_LOAD: begin
          iter  <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          if (iter_done) begin
            out_stream_tvalid <= 1'b1;
            out_stream_tdata  <= colour(iter);
            out_stream_tlast  <= x_wrap;
            out_stream_tuser  <= first_px;
            state             <= S_OUT;
          end else begin
            iter <= iter + ITER_W'(1);
          end
        end
        S_OUT: begin
          if (out_stream_tready) begin
            out_stream_tvalid <= 1'b0;
            if (x_wrap) begin
              x <= '0;
              y <= y_wrap ? '0 : y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
            state <= enable ? S_LOAD : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data: shadow config, per-pixel c and z registers. These registers are not
  // reset because the (0,0) load always refreshes them before they are used.
  always_ff @(posedge aclk) begin
    case (state)
      S_LOAD: begin
        if (first_px) begin
          re0_s      <= cfg_re0;
          im0_s      <= cfg_im0;
          step_s     <= cfg_step;
          max_iter_s <= cfg_max_iter;
          cr         <= cfg_re0;
          ci         <= cfg_im0;
        end
        zr <= '0;
        zi <= '0;
      end
      S_ITER: begin
        if (!iter_done) begin
          zr <= zr_nxt;
          zi <= zi_nxt;
        end
      end
      S_OUT: begin
        if (out_stream_tready) begin
          if (x_wrap) begin
            cr <= re0_s;
            ci <= y_wrap ? im0_s : ci + step_s;
          end else begin
            cr <= cr + step_s;
          end
        end
      end
      default: ;
    endcase
  end

  assign out_stream_tkeep = 4'b1111;
  assign busy             = (state != S_IDLE);
  assign frame_done       = hs && x_wrap && y_wrap;

endmodule

// File: tb/tb_mandelbrot_iter_stream.sv
// Directed bench for mandelbrot_iter_stream on a 4x2 frame in Q4.28 format.
module tb_mandelbrot_iter_stream;

  logic        aclk = 1'b0;
  logic        areset;
  logic        enable;
  logic [31:0] cfg_re0;
  logic [31:0] cfg_im0;
  logic [31:0] cfg_step;
  logic [7:0]  cfg_max_iter;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready;
  logic        busy;
  logic        frame_done;

`ifdef MANDEL_PALETTE_EN
  localparam logic [31:0] C0  = 32'h00000000;
  localparam logic [31:0] C2  = 32'h04080200;
  localparam logic [31:0] C3  = 32'h091B0300;
  localparam logic [31:0] C4  = 32'h10400400;
  localparam logic [31:0] C16 = 32'h00001000;
`else
  localparam logic [31:0] C0  = 32'h00000000;
  localparam logic [31:0] C2  = 32'h02020200;
  localparam logic [31:0] C3  = 32'h03030300;
  localparam logic [31:0] C4  = 32'h04040400;
  localparam logic [31:0] C16 = 32'h10101000;
`endif

  localparam logic [31:0] P2_0  = 32'h20000000;
  localparam logic [31:0] M2_0  = 32'hE0000000;
  localparam logic [31:0] HALF  = 32'h08000000;

  mandelbrot_iter_stream #(
    .X_SIZE(4), .Y_SIZE(2), .WIDTH(32), .FRAC(28), .ITER_W(8)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .enable            (enable),
    .cfg_re0           (cfg_re0),
    .cfg_im0           (cfg_im0),
    .cfg_step          (cfg_step),
    .cfg_max_iter      (cfg_max_iter),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fd_total = 0;

  logic [31:0] q_data[$];
  logic [31:0] q_last[$];
  logic [31:0] q_user[$];
  logic [31:0] q_fd[$];
  int          q_cyc[$];
  logic [31:0] exp_c [9];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Capture every handshake, sampled mid-cycle ahead of the edge that commits it.
  always @(negedge aclk) begin
    cyc++;
    if (out_stream_tvalid && out_stream_tready) begin
      q_data.push_back(out_stream_tdata);
      q_last.push_back(32'(out_stream_tlast));
      q_user.push_back(32'(out_stream_tuser));
      q_fd.push_back(32'(frame_done));
      q_cyc.push_back(cyc);
    end
    if (frame_done) fd_total++;
  end

  task automatic do_reset();
    areset = 1'b1;
    enable = 1'b0;
    out_stream_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    q_data.delete(); q_last.delete(); q_user.delete(); q_fd.delete(); q_cyc.delete();
    fd_total = 0;
  endtask

  task automatic wait_xfers(input string tag, input int n, input int budget);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      @(posedge aclk);
      k++;
    end
    #1;
    check_eq(tag, 32'(q_data.size()), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int diffs;
    int k;
    logic [31:0] d0;
    logic        l0;
    logic        u0;

    exp_c = '{C4, C4, C3, C2, C4, C4, C2, C2, C4};
    cfg_re0 = '0; cfg_im0 = '0; cfg_step = '0; cfg_max_iter = 8'd16;
    areset = 1'b1; enable = 1'b0; out_stream_tready = 1'b1;
    do_reset();

    // Reset state
    @(negedge aclk);
    check_eq("rst_tvalid", 32'(out_stream_tvalid), 0);
    check_eq("rst_tdata",  out_stream_tdata, 0);
    check_eq("rst_tkeep",  32'(out_stream_tkeep), 32'hF);
    check_eq("rst_tlast",  32'(out_stream_tlast), 0);
    check_eq("rst_tuser",  32'(out_stream_tuser), 0);
    check_eq("rst_busy",   32'(busy), 0);
    check_eq("rst_fdone",  32'(frame_done), 0);
    @(posedge aclk); #1;

    // Full frame at c=0, with re0 changed after the second word
    enable = 1'b1;
    wait_xfers("frame_w2", 2, 200);
    cfg_re0 = P2_0;
    wait_xfers("frame_w10", 10, 400);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("frame_data%0d", i), q_data[i], (i < 8) ? C16 : C2);
      check_eq($sformatf("frame_user%0d", i), q_user[i], (i == 0 || i == 8) ? 1 : 0);
      check_eq($sformatf("frame_last%0d", i), q_last[i], (i == 3 || i == 7) ? 1 : 0);
      check_eq($sformatf("frame_fd%0d", i),   q_fd[i],   (i == 7) ? 1 : 0);
    end
    check_eq("frame_fd_total", 32'(fd_total), 1);
    check_eq("frame_cyc_d16", 32'(q_cyc[1] - q_cyc[0]), 19);
    check_eq("frame_cyc_d2",  32'(q_cyc[9] - q_cyc[8]), 5);

    // c=-2.0 sits on |z|=2 and must not escape
    do_reset();
    cfg_re0 = M2_0; cfg_im0 = '0; cfg_step = '0; cfg_max_iter = 8'd16;
    enable = 1'b1;
    wait_xfers("neg2_w1", 1, 100);
    check_eq("neg2_data", q_data[0], C16);

    // Stepped viewport, max_iter=4: line and frame wraps of cr/ci
    do_reset();
    cfg_re0 = '0; cfg_im0 = '0; cfg_step = HALF; cfg_max_iter = 8'd4;
    enable = 1'b1;
    wait_xfers("step_w9", 9, 300);
    for (int i = 0; i < 9; i++)
      check_eq($sformatf("step_data%0d", i), q_data[i], exp_c[i]);
    check_eq("step_cyc_d4", 32'(q_cyc[1] - q_cyc[0]), 7);
    check_eq("step_cyc_d2", 32'(q_cyc[3] - q_cyc[2]), 5);

    // max_iter=0 gives density 0 in three clocks per pixel
    do_reset();
    cfg_re0 = '0; cfg_step = '0; cfg_max_iter = 8'd0;
    enable = 1'b1;
    wait_xfers("max0_w2", 2, 100);
    check_eq("max0_data", q_data[1], C0);
    check_eq("max0_cyc", 32'(q_cyc[1] - q_cyc[0]), 3);

    // Back-pressure: hold tready low for 5 cycles while tvalid is high
    do_reset();
    cfg_re0 = P2_0; cfg_step = '0; cfg_max_iter = 8'd16;
    out_stream_tready = 1'b0;
    enable = 1'b1;
    k = 0;
    @(negedge aclk);
    while (!out_stream_tvalid && k < 100) begin
      @(negedge aclk);
      k++;
    end
    check_eq("stall_vld", 32'(out_stream_tvalid), 1);
    d0 = out_stream_tdata; l0 = out_stream_tlast; u0 = out_stream_tuser;
    diffs = 0;
    repeat (5) begin
      @(negedge aclk);
      if (out_stream_tdata !== d0 || out_stream_tlast !== l0 ||
          out_stream_tuser !== u0 || out_stream_tvalid !== 1'b1)
        diffs++;
    end
    check_eq("stall_stable", 32'(diffs), 0);
    check_eq("stall_noxfer", 32'(q_data.size()), 0);
    @(posedge aclk); #1;
    out_stream_tready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check_eq("stall_vld_drop", 32'(out_stream_tvalid), 0);
    check_eq("stall_one_xfer", 32'(q_data.size()), 1);
    check_eq("stall_data", q_data[0], C2);
    check_eq("stall_user", q_user[0], 1);
    wait_xfers("stall_w4", 4, 100);
    check_eq("stall_user1", q_user[1], 0);
    check_eq("stall_last1", q_last[1], 0);
    check_eq("stall_last3", q_last[3], 1);

    // Reset during ITER of pixel #3, with fresh config applied afterwards
    do_reset();
    cfg_re0 = '0; cfg_step = '0; cfg_max_iter = 8'd16;
    enable = 1'b1;
    wait_xfers("arst_w2", 2, 100);
    repeat (4) @(posedge aclk);
    #1;
    check_eq("arst_busy_pre", 32'(busy), 1);
    areset = 1'b1;
    cfg_re0 = P2_0;
    @(posedge aclk); #1;
    areset = 1'b0;
    q_data.delete(); q_last.delete(); q_user.delete(); q_fd.delete(); q_cyc.delete();
    @(negedge aclk);
    check_eq("arst_tvalid", 32'(out_stream_tvalid), 0);
    check_eq("arst_busy", 32'(busy), 0);
    wait_xfers("arst_w1", 1, 100);
    check_eq("arst_user", q_user[0], 1);
    check_eq("arst_data", q_data[0], C2);

    // Pause with enable=0 after pixel #5, then resume at pixel #6
    do_reset();
    cfg_re0 = P2_0; cfg_step = '0; cfg_max_iter = 8'd16;
    enable = 1'b1;
    wait_xfers("pause_w4", 4, 100);
    enable = 1'b0;
    repeat (20) @(posedge aclk);
    #1;
    check_eq("pause_count", 32'(q_data.size()), 5);
    check_eq("pause_busy", 32'(busy), 0);
    enable = 1'b1;
    wait_xfers("pause_w6", 6, 100);
    check_eq("pause_user5", q_user[4], 0);
    check_eq("pause_user6", q_user[5], 0);
    check_eq("pause_last6", q_last[5], 0);
    check_eq("pause_data6", q_data[5], C2);
    wait_xfers("pause_w8", 8, 100);
    check_eq("pause_fd8", q_fd[7], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
